// File: rtl/counter_ctrl.sv
// Command-driven sequencer for the free-running outCounter datapath: start/stop/hold,
// terminal limit, direct load and auto-reload. Define COUNTER_CTRL_PRESCALE_EN to add a RUN-cycle prescaler.
module counter_ctrl #(
  parameter int WIDTH         = 8,
  parameter int DEFAULT_LIMIT = 255,
  parameter bit AUTO_START    = 1'b1
`ifdef COUNTER_CTRL_PRESCALE_EN
  ,
  parameter int PRESCALE      = 4
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] outCounter,
  output logic             running,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [1:0] OP_START      = 2'd0;
  localparam logic [1:0] OP_STOP       = 2'd1;
  localparam logic [1:0] OP_LOAD_LIMIT = 2'd2;
  localparam logic [1:0] OP_LOAD_COUNT = 2'd3;

  state_t             state_r, state_s;
  logic [WIDTH-1:0]   count_r, count_s;
  logic [WIDTH-1:0]   limit_r, limit_s;
  logic               done_r, done_s;
  logic               running_r;
  logic               ready_s;
  logic               accept_s;
  logic               start_s, stop_s, ld_limit_s, ld_count_s;
  logic               tick_s;

  // Command handshake decode.
  always_comb begin
    if (rst) begin
      ready_s = 1'b0;
    end else begin
      ready_s = (state_r != ST_DONE);
    end
    accept_s   = cmd_valid & ready_s;
    start_s    = accept_s & (cmd_op == OP_START);
    stop_s     = accept_s & (cmd_op == OP_STOP);
    ld_limit_s = accept_s & (cmd_op == OP_LOAD_LIMIT);
    ld_count_s = accept_s & (cmd_op == OP_LOAD_COUNT);
  end

`ifdef COUNTER_CTRL_PRESCALE_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_r, pre_s;

  // Prescaler: clears on START from IDLE and LOAD_COUNT, counts only while RUN advances.
  always_comb begin
    pre_s  = pre_r;
    tick_s = (pre_r == PRE_LAST);
    if ((state_r == ST_IDLE && start_s) || ld_count_s) begin
      pre_s = '0;
    end else if (state_r == ST_RUN && !stop_s) begin
      pre_s = tick_s ? '0 : (pre_r + PW'(1));
    end else begin
      pre_s = pre_r;
    end
  end

  // Prescaler register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_r <= '0;
    end else begin
      pre_r <= pre_s;
    end
  end
`else
  assign tick_s = 1'b1;
`endif

  // Next-state, count, limit and done computation.
  always_comb begin
    state_s = state_r;
    count_s = count_r;
    done_s  = 1'b0;
    if (ld_limit_s) begin
      limit_s = cmd_data;
    end else begin
      limit_s = limit_r;
    end
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          count_s = '0;
          state_s = ST_RUN;
        end else if (ld_count_s) begin
          count_s = cmd_data;
        end else begin
          count_s = count_r;
        end
      end
      ST_HOLD: begin
        if (start_s) begin
          state_s = ST_RUN;
        end else if (ld_count_s) begin
          count_s = cmd_data;
        end else begin
          count_s = count_r;
        end
      end
      ST_RUN: begin
        // STOP and LOAD_COUNT pre-empt a same-edge limit hit; LOAD_LIMIT does not.
        if (stop_s) begin
          state_s = ST_HOLD;
        end else if (ld_count_s) begin
          count_s = cmd_data;
        end else if (!tick_s) begin
          count_s = count_r;
        end else if (count_r == limit_r) begin
          done_s = 1'b1;
          if (auto_reload) begin
            count_s = '0;
          end else begin
            state_s = ST_DONE;
          end
        end else begin
          count_s = count_r + WIDTH'(1);
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= AUTO_START ? ST_RUN : ST_IDLE;
      count_r   <= '0;
      limit_r   <= WIDTH'(DEFAULT_LIMIT);
      done_r    <= 1'b0;
      running_r <= AUTO_START;
    end else begin
      state_r   <= state_s;
      count_r   <= count_s;
      limit_r   <= limit_s;
      done_r    <= done_s;
      running_r <= (state_s == ST_RUN);
    end
  end

  assign cmd_ready  = ready_s;
  assign outCounter = count_r;
  assign running    = running_r;
  assign done       = done_r;

endmodule

// File: tb/tb_counter_ctrl.sv
// Bench for counter_ctrl (default build): directed literal checks plus randomized
// commands, every cycle compared against a behavioural model of the command rules.
module tb_counter_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
  logic       auto_reload;
  logic [7:0] outCounter;
  logic       running;
  logic       done;

  int total = 0;
  int bad   = 0;

  // Model state: count value, limit, mode name, done pulse.
  int    m_cnt  = 0;
  int    m_lim  = 255;
  string m_mode = "run";
  bit    m_done = 1'b0;

  localparam int START = 0;
  localparam int STOP  = 1;
  localparam int LL    = 2;
  localparam int LC    = 3;

  always #5 clk = ~clk;

  counter_ctrl #(.WIDTH(8), .DEFAULT_LIMIT(255), .AUTO_START(1'b1)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .auto_reload(auto_reload),
    .outCounter(outCounter), .running(running), .done(done)
  );

  task automatic check(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic void model_step(bit r, bit v, int op, int d, bit ar);
    bit acc;
    int old_lim;
    acc    = v && !r && (m_mode != "done");
    m_done = 1'b0;
    if (r) begin
      m_cnt = 0; m_lim = 255; m_mode = "run";
      return;
    end
    if (m_mode == "done") begin
      m_mode = "idle";
      return;
    end
    old_lim = m_lim;
    if (acc && op == LL) m_lim = d;
    if (acc && op == LC) begin
      m_cnt = d;
      return;
    end
    if (m_mode == "run") begin
      if (acc && op == STOP) begin
        m_mode = "hold";
      end else if (m_cnt == old_lim) begin
        m_done = 1'b1;
        if (ar) m_cnt = 0;
        else    m_mode = "done";
      end else begin
        m_cnt = (m_cnt + 1) % 256;
      end
    end else if (acc && op == START) begin
      if (m_mode == "idle") m_cnt = 0;
      m_mode = "run";
    end
  endfunction

  task automatic tick(bit r, bit v, int op, int d, bit ar);
    rst = r; cmd_valid = v; cmd_op = 2'(op); cmd_data = 8'(d); auto_reload = ar;
    @(posedge clk);
    model_step(r, v, op, d, ar);
    #1;
    check("count",   int'(outCounter), m_cnt);
    check("running", int'(running), int'(m_mode == "run"));
    check("done",    int'(done), int'(m_done));
    check("ready",   int'(cmd_ready), int'(!rst && m_mode != "done"));
    @(negedge clk);
  endtask

  task automatic idle(int n, bit ar);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 0, 0, ar);
  endtask

  initial begin
    int exp_seq[8];
    int exp_done[8];
    exp_seq  = '{1, 2, 3, 0, 1, 2, 3, 0};
    exp_done = '{0, 0, 0, 1, 0, 0, 0, 1};
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_data = 8'd0; auto_reload = 1'b0;
    @(negedge clk);

    // Reset and legacy auto-start.
    tick(1'b1, 1'b0, 0, 0, 1'b0);
    tick(1'b1, 1'b0, 0, 0, 1'b0);
    check("rst_count", int'(outCounter), 0);
    check("rst_ready", int'(cmd_ready), 0);
    check("rst_done",  int'(done), 0);
    idle(1, 1'b0);
    check("first_inc", int'(outCounter), 1);
    idle(1, 1'b0);
    check("second_inc", int'(outCounter), 2);
    check("auto_running", int'(running), 1);

    // Limit 5, run into DONE, then IDLE.
    tick(1'b0, 1'b1, LL, 5, 1'b0);
    idle(3, 1'b0);
    check("done_pulse", int'(done), 1);
    check("done_ready", int'(cmd_ready), 0);
    check("done_count", int'(outCounter), 5);
    idle(1, 1'b0);
    check("idle_running", int'(running), 0);
    check("idle_count", int'(outCounter), 5);

    // START from IDLE counts 0..5 then done.
    tick(1'b0, 1'b1, START, 0, 1'b0);
    check("start_clear", int'(outCounter), 0);
    idle(5, 1'b0);
    check("reach_limit", int'(outCounter), 5);
    idle(1, 1'b0);
    check("done_again", int'(done), 1);
    idle(1, 1'b0);

    // Auto-reload with limit 3.
    tick(1'b0, 1'b1, LL, 3, 1'b1);
    tick(1'b0, 1'b1, START, 0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      idle(1, 1'b1);
      check("reload_seq", int'(outCounter), exp_seq[i]);
      check("reload_done", int'(done), exp_done[i]);
    end

    // STOP at 7, hold, resume.
    tick(1'b0, 1'b1, LL, 255, 1'b0);
    idle(6, 1'b0);
    check("pre_stop", int'(outCounter), 7);
    tick(1'b0, 1'b1, STOP, 0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      idle(1, 1'b0);
      check("hold_count", int'(outCounter), 7);
    end
    tick(1'b0, 1'b1, START, 0, 1'b0);
    check("resume_no_clear", int'(outCounter), 7);
    idle(1, 1'b0);
    check("resume_8", int'(outCounter), 8);
    idle(1, 1'b0);
    check("resume_9", int'(outCounter), 9);

    // Same-edge priority against a limit hit.
    tick(1'b0, 1'b1, LC, 0, 1'b0);
    tick(1'b0, 1'b1, LL, 5, 1'b0);
    idle(4, 1'b0);
    tick(1'b0, 1'b1, STOP, 0, 1'b0);
    check("stop_hit_count", int'(outCounter), 5);
    check("stop_hit_done", int'(done), 0);
    check("stop_hit_hold", int'(running), 0);
    tick(1'b0, 1'b1, START, 0, 1'b0);
    tick(1'b0, 1'b1, LC, 32, 1'b0);
    check("lc_hit_count", int'(outCounter), 32);
    check("lc_hit_done", int'(done), 0);
    check("lc_hit_run", int'(running), 1);
    tick(1'b0, 1'b1, LC, 5, 1'b1);
    tick(1'b0, 1'b1, LL, 9, 1'b1);
    check("ll_hit_done", int'(done), 1);
    check("ll_hit_count", int'(outCounter), 0);
    idle(9, 1'b1);
    check("new_limit_reached", int'(outCounter), 9);
    idle(1, 1'b1);
    check("new_limit_done", int'(done), 1);

    // Reset mid-run overrides an accepted command.
    tick(1'b0, 1'b1, LL, 16, 1'b0);
    tick(1'b0, 1'b1, LC, 64, 1'b0);
    tick(1'b1, 1'b1, LC, 119, 1'b0);
    check("midrst_count", int'(outCounter), 0);
    check("midrst_ready", int'(cmd_ready), 0);
    idle(20, 1'b0);
    check("limit_restored", int'(outCounter), 20);

    // Randomized commands against the model.
    for (int i = 0; i < 4000; i++) begin
      bit r, v, ar;
      int op, d;
      r  = ($urandom_range(0, 199) == 0);
      v  = ($urandom_range(0, 2) == 0);
      ar = $urandom_range(0, 1) == 1;
      op = $urandom_range(0, 3);
      d  = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : $urandom_range(0, 255);
      tick(r, v, op, d, ar);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/counter_ctrl.md
Name: counter_ctrl

Overview:
- Controller that sequences the design's free-running 8-bit `outCounter` datapath.
- Adds start/stop/hold, a programmable terminal limit, direct count load and an auto-reload mode.
- Driven by a single command channel with a valid/ready handshake.
- Sits between the system control logic and the counter; `top`-level benches observe `outCounter` unchanged.

Parameters:
- WIDTH, 8: counter and command data width.
- DEFAULT_LIMIT, 255: limit register value after reset.
- AUTO_START, 1: 1 = enter RUN directly out of reset (legacy free-running behaviour); 0 = enter IDLE.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command.
- cmd_op  in  2  0=START, 1=STOP, 2=LOAD_LIMIT, 3=LOAD_COUNT.
- cmd_data  in  WIDTH  operand for LOAD_LIMIT / LOAD_COUNT; ignored otherwise.
- auto_reload  in  1  sampled each cycle; 1 = wrap to 0 at limit and keep running.
- outCounter  out  WIDTH  current count (registered).
- running  out  1  high while in RUN.
- done  out  1  one-cycle pulse on each limit hit.

Behaviour:
- Reset (rst high at an edge):
  - outCounter=0, limit=DEFAULT_LIMIT, done=0.
  - State=RUN if AUTO_START else IDLE; running follows the state.
  - cmd_ready is forced 0 while rst is high.
- Handshake:
  - A command is accepted when cmd_valid & cmd_ready at a rising edge.
  - cmd_ready = !rst && state!=DONE (combinational).
  - cmd_valid may be held; each accepting edge consumes one command.
- States IDLE, RUN, HOLD, DONE (registered); transitions:
  - IDLE: counter frozen. START -> outCounter<=0, go RUN.
  - RUN: outCounter<=outCounter+1 each cycle, modulo 2^WIDTH. First increment lands on the edge after START is accepted, or on the first edge after reset release. With AUTO_START=1 the count reads 1 one cycle after rst deasserts.
  - RUN limit hit (outCounter==limit, equality compare):
    - auto_reload=1: next outCounter=0, done=1 for one cycle, stay RUN.
    - auto_reload=0: outCounter holds the limit value, done=1, go DONE.
  - RUN STOP -> HOLD; the counter does not increment on the accepting edge.
  - HOLD: counter frozen. START resumes RUN from the held value, with no clear.
  - DONE: lasts exactly one cycle, cmd_ready=0, counter held, then -> IDLE.
- LOAD_LIMIT: limit<=cmd_data in any state where accepted; no state change.
- LOAD_COUNT: outCounter<=cmd_data in any state where accepted, replacing that cycle's increment; no state change.
- START while in RUN: accepted, no effect.
- STOP in IDLE/HOLD: accepted, no effect.
- Limit below the current count: the counter runs up to 2^WIDTH-1, wraps to 0, then hits the limit. No special case.
- Limit = 0 with auto_reload=1: done pulses every cycle after the counter reaches 0.
- Same-edge priority, command vs. limit hit in RUN:
  - STOP: -> HOLD, counter holds the limit value, no done.
  - LOAD_COUNT: loaded value wins, no done.
  - LOAD_LIMIT: the hit is evaluated against the old limit (done fires); the new limit applies from the next cycle.
  - START: the limit-hit rule applies normally.
- Reset mid-operation: rst overrides everything including an accepted command; all state returns to reset values on that edge.
- done never asserts while rst is high.

Optional Feature:
- Macro COUNTER_CTRL_PRESCALE_EN. When defined, the block adds parameter PRESCALE (default 4, must be ≥1) and an internal prescale counter:
  - In RUN, outCounter advances (and limit hits are evaluated) only on every PRESCALE-th cycle.
  - The prescaler clears on reset, START from IDLE, and LOAD_COUNT.
  - The prescaler freezes in HOLD and resumes from its frozen value.
- When undefined, the block advances every RUN cycle with no extra logic or parameter.

Test Plan:
- AUTO_START=1, release rst at a negedge: outCounter is 1 after the first subsequent negedge and 2 after the second; running=1, done=0.
- LOAD_LIMIT 5, auto_reload=0, then START from IDLE: the count goes 1..5; done pulses once in the cycle entering DONE; cmd_ready=0 for that one cycle; state then IDLE with outCounter held at 5.
- auto_reload=1, limit 3: the sequence is 1,2,3,0,1,2,3,0; done is high exactly in the cycles where the count goes 3->0.
- STOP at count 7, idle 10 cycles, then START: the count holds 7 throughout HOLD and resumes 8, 9.
- Same edge as a limit hit of 5: STOP -> count stays 5, no done, state HOLD. Repeat with LOAD_COUNT 0x20 -> count 0x20, no done, stays RUN.
- Assert rst for one cycle while in RUN at count 0x40 with limit 0x10: the next cycle shows count 0, limit 255, done=0, cmd_ready=0 during reset. With COUNTER_CTRL_PRESCALE_EN and PRESCALE=4, the count increments once per 4 clocks.
